// File: rtl/serial_subtractor_pkg.sv
// Shared FSM encoding for the bit-serial subtractor.
package serial_subtractor_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = x_i ^ y_i ^ bin_i;
  assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock; WIDTH RUN cycles then a done pulse.
// New requests are taken in IDLE or DONE only; start during RUN is ignored.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bor_q, bor_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             cell_d, cell_bout;

  full_subtractor u_fs (
    .x_i   (a_sh_q[0]),
    .y_i   (b_sh_q[0]),
    .bin_i (bor_q),
    .d_o   (cell_d),
    .bout_o(cell_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    bor_d   = bor_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_q >> 1;
        res_d[WIDTH-1] = cell_d;
        bor_d  = cell_bout;
        cnt_d  = cnt_q + 1'b1;
        // Final bit: publish the completed result on this same edge.
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          diff_d  = res_d;
          bout_d  = cell_bout;
        end
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          bor_d   = borrow_in;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      bor_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      bor_q   <= bor_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign difference = diff_q;
  assign borrow_out = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks of the serial subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, bi8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;

  logic       start1 = 1'b0, bi1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, bo1;
  logic [0:0] diff1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .borrow_in(bi8),
    .busy(busy8), .done(done8), .difference(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .borrow_in(bi1),
    .busy(busy1), .done(done1), .difference(diff1), .borrow_out(bo1)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] prev8 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                      input logic [7:0] exp_d, input logic exp_b, input string tag);
    int n;
    @(negedge clk);
    a8 = av; b8 = bv; bi8 = bi; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~av; b8 = ~bv;
    n = 1;
    chk({tag, "_busy"}, busy8, 1);
    chk({tag, "_hold"}, diff8, prev8);
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_diff"}, diff8, exp_d);
    chk({tag, "_bout"}, bo8, exp_b);
    chk({tag, "_nbusy"}, busy8, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, done8, 0);
    prev8 = exp_d;
  endtask

  task automatic run1(input int idx);
    int n;
    int t;
    logic av, bv, bi;
    av = idx[2]; bv = idx[1]; bi = idx[0];
    t = int'(av) - int'(bv) - int'(bi);
    @(negedge clk);
    a1 = av; b1 = bv; bi1 = bi; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("w1_lat_%0d", idx), n, 2);
    chk($sformatf("w1_diff_%0d", idx), diff1, t & 1);
    chk($sformatf("w1_bout_%0d", idx), bo1, (t < 0) ? 1 : 0);
  endtask

  initial begin
    int n, dn, viol, per_bad, last, first, extra;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_bout", bo8, 0);
    chk("rst1_diff", diff1, 0);
    reset = 1'b0;

    // Basic vectors
    run8(8'd200, 8'd55, 1'b0, 8'd145, 1'b0, "t1");
    run8(8'd5, 8'd9, 1'b1, 8'd251, 1'b1, "t2a");
    run8(8'd0, 8'd0, 1'b1, 8'd255, 1'b1, "t2b");
    run8(8'd255, 8'd255, 1'b0, 8'd0, 1'b0, "t2c");
    run8(8'd0, 8'd255, 1'b0, 8'd1, 1'b1, "t2d");

    // Start held high: back-to-back operations
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd20; bi8 = 1'b0; start8 = 1'b1;
    dn = 0; viol = 0; per_bad = 0; last = -1; first = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy8 && done8) viol++;
      if (!busy8 && !done8) viol++;
      if (done8) begin
        if (first < 0) first = c;
        if (last >= 0 && (c - last) != 9) per_bad++;
        last = c;
        dn++;
      end
    end
    chk("t3_first", first, 8);
    chk("t3_count", dn, 4);
    chk("t3_period", per_bad, 0);
    chk("t3_busy_done", viol, 0);
    chk("t3_diff", diff8, 30);
    start8 = 1'b0;
    n = 0;
    while ((busy8 || done8) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t3_drain", {busy8, done8}, 0);

    // Start pulsed and operands changed mid-RUN
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd3; bi8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'd99; b8 = 8'd1; bi8 = 1'b1;
    n = 1;
    repeat (3) begin @(negedge clk); n++; end
    start8 = 1'b1;
    @(negedge clk);
    n++;
    start8 = 1'b0; a8 = 8'd200;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t4_lat", n, 9);
    chk("t4_diff", diff8, 7);
    chk("t4_bout", bo8, 0);
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    chk("t4_extra", extra, 0);

    // Reset mid-RUN
    @(negedge clk);
    a8 = 8'd77; b8 = 8'd7; bi8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_rst_busy", busy8, 0);
    chk("t5_rst_done", done8, 0);
    chk("t5_rst_diff", diff8, 0);
    chk("t5_rst_bout", bo8, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8) extra++;
    end
    chk("t5_no_done", extra, 0);
    prev8 = 8'd0;
    run8(8'd100, 8'd1, 1'b0, 8'd99, 1'b0, "t5");

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) run1(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
